// File: rtl/mem_io_bridge_if.sv
// CPU memory bus bundle between a bus master and mem_io_bridge.
// The master drives address, write data and strobe; the bridge returns read data.
interface mem_io_bridge_if #(
   parameter int M = 16
);
   logic [M-1:0] memAddr;
   logic [M-1:0] memWrite;
   logic         memWE;
   logic [M-1:0] memRead;

   modport master (
      output memAddr,
      output memWrite,
      output memWE,
      input  memRead
   );

   modport slave (
      input  memAddr,
      input  memWrite,
      input  memWE,
      output memRead
   );
endinterface

// File: rtl/mem_io_bridge.sv
// Memory-mapped bridge: async-read RAM, 4-deep UART TX FIFO with 8N1 serialiser,
// free-running TICK counter.
module mem_io_bridge #(
   parameter int M            = 16,
   parameter int RAM_WORDS    = 256,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic           clk,
   input  logic           rst,
   mem_io_bridge_if.slave bus,
   output logic           txd
);
   localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [M-1:0] A_DATA = M'(16'hFFF0);
   localparam logic [M-1:0] A_STAT = M'(16'hFFF1);
   localparam logic [M-1:0] A_TICK = M'(16'hFFF2);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        r_state, w_nstate;
   logic [M-1:0]  r_ram [RAM_WORDS];
   logic [7:0]    r_fifo [4];
   logic [1:0]    r_wptr, r_rptr;
   logic [2:0]    r_count;
   logic          r_ovf;
   logic [CW-1:0] r_cnt, w_ncnt;
   logic [2:0]    r_bit, w_nbit;
   logic [7:0]    r_shift, w_nshift;
   logic [15:0]   r_tick;

   logic w_is_ram, w_is_data, w_is_stat, w_is_tick;
   logic w_full, w_empty, w_push, w_acc, w_pop, w_last;
   logic [3:0] w_status;

   assign w_is_ram  = bus.memAddr < M'(RAM_WORDS);
   assign w_is_data = bus.memAddr == A_DATA;
   assign w_is_stat = bus.memAddr == A_STAT;
   assign w_is_tick = bus.memAddr == A_TICK;
   assign w_full    = r_count == 3'd4;
   assign w_empty   = r_count == 3'd0;
   assign w_push    = rst && bus.memWE && w_is_data;
   // A push into a full FIFO survives only if the same edge frees a slot.
   assign w_acc     = w_push && (!w_full || w_pop);
   assign w_last    = r_cnt == LAST;
   assign w_status  = {r_ovf, r_state != IDLE, w_empty, w_full};

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_nbit   = r_bit;
      w_nshift = r_shift;
      w_pop    = 1'b0;
      txd      = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop    = 1'b1;
               w_nstate = START;
               w_ncnt   = '0;
               w_nshift = r_fifo[r_rptr];
            end
         end
         START: begin
            txd = 1'b0;
            if (w_last) begin
               w_nstate = DATA;
               w_ncnt   = '0;
               w_nbit   = 3'd0;
            end else begin
               w_ncnt = r_cnt + CW'(1);
            end
         end
         DATA: begin
            txd = r_shift[0];
            if (w_last) begin
               w_ncnt   = '0;
               w_nshift = r_shift >> 1;
               if (r_bit == 3'd7) w_nstate = STOP;
               else               w_nbit   = r_bit + 3'd1;
            end else begin
               w_ncnt = r_cnt + CW'(1);
            end
         end
         STOP: begin
            if (w_last) begin
               w_ncnt = '0;
               // Chain straight into the next frame with no idle gap.
               if (!w_empty) begin
                  w_pop    = 1'b1;
                  w_nstate = START;
                  w_nshift = r_fifo[r_rptr];
               end else begin
                  w_nstate = IDLE;
               end
            end else begin
               w_ncnt = r_cnt + CW'(1);
            end
         end
         default: w_nstate = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         r_bit   <= w_nbit;
         r_shift <= w_nshift;
      end
   end

   always_ff @(posedge clk) begin
      if (w_acc) r_fifo[r_wptr] <= bus.memWrite[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 3'd0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_acc) r_wptr <= r_wptr + 2'd1;
         if (w_pop) r_rptr <= r_rptr + 2'd1;
         case ({w_acc, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
         if (bus.memWE && w_is_stat) r_ovf <= 1'b0;
         else if (w_push && !w_acc)  r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)                        r_tick <= 16'd0;
      else if (bus.memWE && w_is_tick) r_tick <= bus.memWrite[15:0];
      else                             r_tick <= r_tick + 16'd1;
   end

   // RAM has no reset so its contents survive a bridge reset.
   always_ff @(posedge clk) begin
      if (bus.memWE && w_is_ram) r_ram[bus.memAddr[AW-1:0]] <= bus.memWrite;
   end

   always_comb begin
      bus.memRead = '0;
      if (w_is_ram)       bus.memRead = r_ram[bus.memAddr[AW-1:0]];
      else if (w_is_stat) bus.memRead = M'(w_status);
      else if (w_is_tick) bus.memRead = M'(r_tick);
   end
endmodule
